// File: rtl/alu_exec_unit_if.sv
// Interface bundling the dispatch port from the ALU reservation station
// and the CDB port toward the arbiter for alu_exec_unit.
// master: station/arbiter side; slave: the execute unit.
interface alu_exec_unit_if #(
  parameter int OP_W  = 4,
  parameter int ROB_W = 3
);
  logic [OP_W-1:0]  Op_in;
  logic [31:0]      Vj_in;
  logic [31:0]      Vk_in;
  logic [ROB_W-1:0] Dest_in;
  logic             full;
  logic             cdb_valid;
  logic             cdb_grant;
  logic [ROB_W-1:0] CDB_ALU_ROB_index;
  logic [31:0]      CDB_ALU_data;
  logic             overflow;

  modport master (
    output Op_in, Vj_in, Vk_in, Dest_in, cdb_grant,
    input  full, cdb_valid, CDB_ALU_ROB_index, CDB_ALU_data, overflow
  );

  modport slave (
    input  Op_in, Vj_in, Vk_in, Dest_in, cdb_grant,
    output full, cdb_valid, CDB_ALU_ROB_index, CDB_ALU_data, overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer ALU function unit. One op per cycle is captured
// into a single pipeline register (S1), evaluated combinationally, and the
// result is pushed into a small in-order queue that drains onto the ALU CDB
// under a valid/grant handshake. Optional macro ALU_CDB_BYPASS_EN lets an
// S1 result go straight to the CDB when the queue is empty.
module alu_exec_unit #(
  parameter int OP_W   = 4,
  parameter int ROB_W  = 3,
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_W + 32;

  // Result of one op; shift amount is always the low five bits of operand B.
  function automatic logic signed [31:0] alu_fn(
    input logic        [OP_W-1:0] op,
    input logic signed [31:0]     a,
    input logic signed [31:0]     b
  );
    logic [4:0]         sh;
    logic signed [31:0] r;
    sh = b[4:0];
    case (op)
      OP_W'(0): r = a + b;
      OP_W'(1): r = a - b;
      OP_W'(2): r = a & b;
      OP_W'(3): r = a | b;
      OP_W'(4): r = a ^ b;
      OP_W'(5): r = a << sh;
      OP_W'(6): r = $signed($unsigned(a) >> sh);
      OP_W'(7): r = a >>> sh;
      OP_W'(8): r = (a < b) ? 32'sd1 : 32'sd0;
      OP_W'(9): r = ($unsigned(a) < $unsigned(b)) ? 32'sd1 : 32'sd0;
      default:  r = 32'sd0;
    endcase
    return r;
  endfunction

  // ---------------- S1: dispatch capture ----------------
  logic        [OP_W-1:0]  op_p1;
  logic signed [31:0]      vj_p1;
  logic signed [31:0]      vk_p1;
  logic        [ROB_W-1:0] dest_p1;
  logic                    vld_p1;
  logic signed [31:0]      res_p1;

  // Operand capture every edge; qualified by vld_p1, so no reset needed.
  always_ff @(posedge clk) begin
    op_p1   <= bus.Op_in;
    vj_p1   <= $signed(bus.Vj_in);
    vk_p1   <= $signed(bus.Vk_in);
    dest_p1 <= bus.Dest_in;
  end

  // S1 is valid whenever the station presented a non-zero ROB index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= (bus.Dest_in != '0);
  end

  assign res_p1 = alu_fn(op_p1, vj_p1, vk_p1);

  // ---------------- S2: result queue and CDB ----------------
  logic [ENT_W-1:0] q_mem [QDEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             q_vld;
  logic             byp;
  logic             pop;
  logic             byp_take;
  logic             push;
  logic             drop;
  logic             push_ok;
  logic [ENT_W-1:0] head_ent;

  assign q_vld    = (count != '0);
  assign head_ent = q_mem[head];

`ifdef ALU_CDB_BYPASS_EN
  assign byp = (count == '0) && vld_p1;
`else
  assign byp = 1'b0;
`endif

  assign pop      = q_vld && bus.cdb_grant;
  assign byp_take = byp && bus.cdb_grant;
  assign push     = vld_p1 && !byp_take;
  // A full queue only accepts a push when the head leaves in the same cycle.
  assign drop     = push && (count == CNT_W'(QDEPTH)) && !pop;
  assign push_ok  = push && !drop;

  // Queue bookkeeping and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      count      <= count + CNT_W'(push_ok) - CNT_W'(pop);
      overflow_q <= overflow_q || drop;
    end
  end

  // Queue storage; occupancy is tracked by count, so entries are not reset.
  always_ff @(posedge clk) begin
    if (push_ok) q_mem[tail] <= {dest_p1, res_p1};
  end

  // CDB drive: queue head first, else bypassed S1 result, else idle zeros.
  always_comb begin
    bus.cdb_valid         = 1'b0;
    bus.CDB_ALU_ROB_index = '0;
    bus.CDB_ALU_data      = '0;
    if (q_vld) begin
      bus.cdb_valid         = 1'b1;
      bus.CDB_ALU_ROB_index = head_ent[ENT_W-1:32];
      bus.CDB_ALU_data      = head_ent[31:0];
    end else if (byp) begin
      bus.cdb_valid         = 1'b1;
      bus.CDB_ALU_ROB_index = dest_p1;
      bus.CDB_ALU_data      = res_p1;
    end
  end

  // Conservative hint: leaves a slot for the op the station issues while
  // it is still seeing full low.
  assign bus.full     = (count + CNT_W'(vld_p1)) >= CNT_W'(QDEPTH - 1);
  assign bus.overflow = overflow_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer ALU function unit downstream of the ALU reservation station.
- Accepts one dispatched op per cycle (Op, Vj, Vk, Dest), executes through a one-stage pipeline register, and buffers results in a small in-order queue.
- Broadcasts queued results on the ALU CDB (ROB index + data) under a valid/grant handshake with the CDB arbiter.
- Exports a conservative `full` hint so the station stops dispatching before the queue overflows.

Parameters:
- OP_W, 4, ALU op code width (matches ALU_OP_WIDTH).
- ROB_W, 3, ROB index width (matches ROB_ENTRY_WIDTH); index 0 means "no entry".
- QDEPTH, 4, result queue depth in entries, power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Op_in  in  OP_W  op code from the reservation station.
- Vj_in  in  32  operand A.
- Vk_in  in  32  operand B.
- Dest_in  in  ROB_W  destination ROB index; 0 means no dispatch this cycle.
- full  out  1  dispatch-stall hint to the reservation station.
- cdb_valid  out  1  a result is presented on the CDB.
- cdb_grant  in  1  arbiter accepts the presented result this cycle.
- CDB_ALU_ROB_index  out  ROB_W  ROB index of the presented result; 0 when cdb_valid=0.
- CDB_ALU_data  out  32  result data; 0 when cdb_valid=0.
- overflow  out  1  sticky error flag: a result was dropped.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - S1 valid, queue head, tail and count all clear.
  - overflow=0, cdb_valid=0, CDB_ALU_ROB_index=0, CDB_ALU_data=0, full=0.
  - A reset mid-operation discards all in-flight and queued results.
- Stage S1:
  - At each edge, S1 captures Op_in, Vj_in, Vk_in and Dest_in.
  - S1 valid = (Dest_in != 0).
- ALU, combinational on S1, all ops 32-bit:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is Vk[4:0].
  - 8 SLT (signed), 9 SLTU: result is 32'd1 or 32'd0.
  - Any other op code: result 0.
  - Add and subtract wrap modulo 2^32; no flags.
- Enqueue:
  - If S1 is valid, the edge after capture writes {Dest, result} at the queue tail.
  - Latency: dispatch sampled at edge k → entry visible on the CDB after edge k+1 (2 cycles), provided the queue was empty.
- CDB:
  - cdb_valid = (count != 0).
  - The outputs show the head entry combinationally.
  - On cdb_valid & cdb_grant at an edge, the head is popped.
  - cdb_grant while cdb_valid=0 is ignored.
- Simultaneous push and pop: count unchanged, and both pointers advance modulo QDEPTH.
- full = (count + S1valid) >= QDEPTH-1. This leaves room for one op already dispatched in the same cycle the station samples full.
- Overflow:
  - Trigger: a push when count==QDEPTH and no pop in the same cycle.
  - The result is dropped and overflow is set to 1.
  - overflow stays set until reset.
- Ordering: results leave strictly in dispatch order.

Optional Feature:
- Macro: ALU_CDB_BYPASS_EN.
- Defined:
  - When count==0 and S1 is valid, the CDB outputs drive S1's result directly, with cdb_valid=1.
  - If granted, the result is not enqueued. Latency drops to 1 cycle.
  - If not granted, the result is enqueued normally.
- Undefined: the CDB is always driven from the queue head only.

Test Plan:
- Reset and idle: hold rst_n=0 mid-stream with 3 queued entries, then release. Required: cdb_valid=0, index=0, data=0, full=0, overflow=0.
- Single op, grant held at 1:
  - Stimulus: Op=0, Vj=5, Vk=7, Dest=3 for one cycle.
  - Required: index=3, data=12 on cycle k+2 (k+1 with ALU_CDB_BYPASS_EN), then cdb_valid=0.
- Op sweep:
  - SUB 0-1 → 0xFFFFFFFF.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLL by Vk=33 → shift 1.
  - SLT -1<1 → 1.
  - SLTU 0xFFFFFFFF<1 → 0.
  - Op 15 → 0.
- Backpressure and order:
  - Stimulus: grant=0; dispatch Dest=1,2,3 on consecutive cycles.
  - Required: full asserts at count+S1valid≥3; head stays at 1.
  - Then grant=1 → indices 1,2,3 on consecutive cycles.
- Simultaneous push and pop:
  - Stimulus: steady stream with grant=1 and queue holding 1 entry.
  - Required: count stays 1 and no entry is lost across 8 ops.
- Overflow:
  - Stimulus: ignore full; grant=0; dispatch 6 ops with QDEPTH=4.
  - Required: overflow=1 and stays set; the first 4 results are retained in order; the later results are dropped.
